// File: rtl/fpu_chain_seq.sv
// fpu_chain_seq
// Sequencer for an external 10-bit combinational FPU (1 sign, 4 exp bias 7, 5 mantissa).
// It accepts a stream of beats and runs a chain of operations of the form acc = acc OP b.
// Each FPU result is registered back into the accumulator. The final accumulator is
// returned on a valid/ready result port.
//
// Ports
//   clock, reset           rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready      beat handshake
//   in_data                operand (A on the first beat, B on later beats)
//   in_op                  00 ADD, 01 SUB, 10 MUL, 11 NOP (ignored on the first beat)
//   in_first/in_last       chain start / chain end markers
//   fpu_a/fpu_b/fpu_sel    FPU operand and select drive (register outputs only)
//   fpu_y                  FPU combinational result
//   out_valid/out_ready    result handshake; out_data is the accumulator
//   op_count               number of ops executed in the current or last chain
//   nan_seen/ovf_seen      sticky per-chain NaN / overflow(inf) indicators
module fpu_chain_seq #(
    parameter int MAX_OPS = 15
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [9:0] in_data,
    input  logic [1:0] in_op,
    input  logic       in_first,
    input  logic       in_last,
    output logic [9:0] fpu_a,
    output logic [9:0] fpu_b,
    output logic [3:0] fpu_sel,
    input  logic [9:0] fpu_y,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [9:0] out_data,
    output logic [3:0] op_count,
    output logic       nan_seen,
    output logic       ovf_seen
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_WAIT_B = 2'd1;
    localparam logic [1:0] S_EXEC   = 2'd2;
    localparam logic [1:0] S_RESULT = 2'd3;

    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_NOP = 2'b11;

    localparam logic [4:0] MAX_OPS_W = 5'(MAX_OPS);

    logic [1:0] state_q, state_d;
    logic [9:0] acc_q, acc_d;
    logic [9:0] b_q, b_d;
    logic [1:0] op_q, op_d;
    logic [3:0] cnt_q, cnt_d;
    logic       nan_q, nan_d;
    logic       ovf_q, ovf_d;
    logic       last_pend_q, last_pend_d;

    logic       accept;
    logic [4:0] cnt_inc;
    logic       y_nan;
    logic       y_ovf;

    assign in_ready  = (state_q == S_IDLE) || (state_q == S_WAIT_B);
    assign out_valid = (state_q == S_RESULT);
    assign accept    = in_valid && in_ready;

    // The increment is one bit wider so that the MAX_OPS compare cannot alias on wrap.
    assign cnt_inc   = {1'b0, cnt_q} + 5'd1;
    assign y_nan     = (fpu_y == 10'h3FF);
    assign y_ovf     = (fpu_y[8:5] == 4'hF) && (fpu_y[4:0] == 5'd0);

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        b_d         = b_q;
        op_d        = op_q;
        cnt_d       = cnt_q;
        nan_d       = nan_q;
        ovf_d       = ovf_q;
        last_pend_d = last_pend_q;
        case (state_q)
            S_IDLE, S_WAIT_B: begin
                if (accept) begin
                    if (in_first) begin
                        // A first beat also restarts a chain that is waiting for B.
                        acc_d   = in_data;
                        cnt_d   = 4'd0;
                        nan_d   = 1'b0;
                        ovf_d   = 1'b0;
                        state_d = in_last ? S_RESULT : S_WAIT_B;
                    end else if (state_q == S_WAIT_B) begin
                        b_d         = in_data;
                        op_d        = in_op;
                        last_pend_d = in_last;
                        state_d     = S_EXEC;
                    end
                    // A non-first beat in IDLE is dropped.
                end
            end
            S_EXEC: begin
                if (op_q != OP_NOP) begin
                    acc_d = fpu_y;
                    nan_d = nan_q | y_nan;
                    ovf_d = ovf_q | y_ovf;
                end
                cnt_d   = cnt_inc[3:0];
                state_d = (last_pend_q || (cnt_inc == MAX_OPS_W)) ? S_RESULT : S_WAIT_B;
            end
            default: begin
                if (out_ready) state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            acc_q       <= 10'd0;
            b_q         <= 10'd0;
            op_q        <= 2'b00;
            cnt_q       <= 4'd0;
            nan_q       <= 1'b0;
            ovf_q       <= 1'b0;
            last_pend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            b_q         <= b_d;
            op_q        <= op_d;
            cnt_q       <= cnt_d;
            nan_q       <= nan_d;
            ovf_q       <= ovf_d;
            last_pend_q <= last_pend_d;
        end
    end

    // NOP presents ADD to the FPU. Its result is discarded in EXEC.
    always_comb begin
        case (op_q)
            OP_SUB:  fpu_sel = 4'b0010;
            OP_MUL:  fpu_sel = 4'b0100;
            default: fpu_sel = 4'b0001;
        endcase
    end

    assign fpu_a    = acc_q;
    assign fpu_b    = b_q;
    assign out_data = acc_q;
    assign op_count = cnt_q;
    assign nan_seen = nan_q;
    assign ovf_seen = ovf_q;

endmodule

// File: tb/tb_fpu_chain_seq.sv
// Testbench for fpu_chain_seq. A simplified FPU stand-in drives fpu_y. Any operand
// with exponent 4'hF yields NaN 10'h3FF. Finite results are computed in real
// arithmetic, truncated, and clipped to +/-inf.
// The expected state is kept at the chain/beat level and compared every cycle.
module tb_fpu_chain_seq;

    logic       clock = 1'b0;
    logic       reset;
    logic       in_valid, in_ready, in_first, in_last;
    logic [9:0] in_data;
    logic [1:0] in_op;
    logic [9:0] fpu_a, fpu_b, fpu_y;
    logic [3:0] fpu_sel;
    logic       out_valid, out_ready;
    logic [9:0] out_data;
    logic [3:0] op_count;
    logic       nan_seen, ovf_seen;

    fpu_chain_seq #(.MAX_OPS(15)) dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_op(in_op),
        .in_first(in_first), .in_last(in_last),
        .fpu_a(fpu_a), .fpu_b(fpu_b), .fpu_sel(fpu_sel), .fpu_y(fpu_y),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .op_count(op_count), .nan_seen(nan_seen), .ovf_seen(ovf_seen)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    // ---------------- number format helpers ----------------
    function automatic real pow2(input int e);
        real r = 1.0;
        if (e >= 0) for (int i = 0; i < e; i++) r = r * 2.0;
        else        for (int i = 0; i < -e; i++) r = r / 2.0;
        return r;
    endfunction

    function automatic real dec(input logic [9:0] x);
        real m;
        int  e;
        e = int'(x[8:5]);
        if (e == 0) m = (real'(x[4:0]) / 32.0) * pow2(-6);
        else        m = (1.0 + real'(x[4:0]) / 32.0) * pow2(e - 7);
        return x[9] ? -m : m;
    endfunction

    function automatic logic [9:0] enc(input real v);
        logic s;
        real  m;
        int   e;
        int   mt;
        logic [3:0] ef;
        s = (v < 0.0);
        m = s ? -v : v;
        if (m == 0.0) return {s, 9'd0};
        e = 0;
        while (m >= 2.0) begin m = m / 2.0; e++; end
        while (m < 1.0 && e > -6) begin m = m * 2.0; e--; end
        if (e + 7 >= 15) return {s, 4'hF, 5'd0};
        if (m < 1.0) begin
            mt = $rtoi(m * 32.0);
            return {s, 4'd0, mt[4:0]};
        end
        mt = $rtoi((m - 1.0) * 32.0);
        ef = 4'(e + 7);
        return {s, ef, mt[4:0]};
    endfunction

    // FPU stand-in, keyed by the one-hot select the DUT drives.
    function automatic logic [9:0] fpu_stub(input logic [9:0] a, input logic [9:0] b,
                                            input logic [3:0] sel);
        if (a[8:5] == 4'hF || b[8:5] == 4'hF) return 10'h3FF;
        case (sel)
            4'b0001: return enc(dec(a) + dec(b));
            4'b0010: return enc(dec(a) - dec(b));
            4'b0100: return enc(dec(a) * dec(b));
            default: return 10'h3FF;
        endcase
    endfunction

    assign fpu_y = fpu_stub(fpu_a, fpu_b, fpu_sel);

    // Reference arithmetic keyed by opcode rather than by select.
    function automatic logic [9:0] ref_op(input logic [9:0] a, input logic [9:0] b,
                                          input logic [1:0] op);
        if (a[8:5] == 4'hF || b[8:5] == 4'hF) return 10'h3FF;
        case (op)
            2'b00:   return enc(dec(a) + dec(b));
            2'b01:   return enc(dec(a) - dec(b));
            default: return enc(dec(a) * dec(b));
        endcase
    endfunction

    function automatic logic [3:0] exp_sel(input logic [1:0] op);
        case (op)
            2'b01:   return 4'b0010;
            2'b10:   return 4'b0100;
            default: return 4'b0001;
        endcase
    endfunction

    // ---------------- model state ----------------
    logic [9:0] m_acc, m_b;
    logic [1:0] m_op;
    int         m_cnt;
    logic       m_nan, m_ovf;
    logic       exp_ready, exp_valid;
    logic       chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
        end
    endtask

    task automatic model_reset();
        m_acc = 10'd0; m_b = 10'd0; m_op = 2'b00; m_cnt = 0;
        m_nan = 1'b0; m_ovf = 1'b0; exp_ready = 1'b1; exp_valid = 1'b0;
    endtask

    // Compare process: runs mid-cycle, away from the active edge.
    always @(negedge clock) begin
        if (chk_en) begin
            chk("in_ready",  32'(in_ready),  32'(exp_ready));
            chk("out_valid", 32'(out_valid), 32'(exp_valid));
            chk("op_count",  32'(op_count),  32'(m_cnt));
            chk("nan_seen",  32'(nan_seen),  32'(m_nan));
            chk("ovf_seen",  32'(ovf_seen),  32'(m_ovf));
            chk("fpu_a",     32'(fpu_a),     32'(m_acc));
            chk("fpu_b",     32'(fpu_b),     32'(m_b));
            chk("fpu_sel",   32'(fpu_sel),   32'(exp_sel(m_op)));
            if (exp_valid) chk("out_data", 32'(out_data), 32'(m_acc));
        end
    end

    // ---------------- drivers ----------------
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [9:0] rand_val();
        logic [9:0] v;
        case ($urandom_range(0, 11))
            0: v = 10'h0E0;  1: v = 10'h100;  2: v = 10'h110;  3: v = 10'h000;
            4: v = 10'h2E0;  5: v = 10'h0F0;  6: v = 10'h1C0;  7: v = 10'h3FF;
            default: v = 10'($urandom);
        endcase
        return v;
    endfunction

    task automatic junk_in(input logic allow);
        in_valid = allow ? 1'($urandom_range(0, 1)) : 1'b0;
        in_first = 1'($urandom);
        in_last  = 1'($urandom);
        in_data  = 10'($urandom);
        in_op    = 2'($urandom);
    endtask

    task automatic beat_first(input logic [9:0] a, input logic last);
        in_valid = 1'b1; in_first = 1'b1; in_last = last; in_data = a; in_op = 2'($urandom);
        tick();
        in_valid = 1'b0;
        m_acc = a; m_cnt = 0; m_nan = 1'b0; m_ovf = 1'b0;
        exp_ready = !last; exp_valid = last;
    endtask

    task automatic beat_op(input logic [9:0] b, input logic [1:0] op, input logic last,
                           output logic done);
        logic [9:0] y;
        in_valid = 1'b1; in_first = 1'b0; in_last = last; in_data = b; in_op = op;
        tick();
        m_b = b; m_op = op; exp_ready = 1'b0; exp_valid = 1'b0;
        junk_in(1'b1);               // ignored while executing
        tick();
        in_valid = 1'b0;
        if (op != 2'b11) begin
            y = ref_op(m_acc, b, op);
            m_nan = m_nan | (y == 10'h3FF);
            m_ovf = m_ovf | (y[8:5] == 4'hF && y[4:0] == 5'd0);
            m_acc = y;
        end
        m_cnt++;
        done = last || (m_cnt == 15);
        exp_ready = !done; exp_valid = done;
    endtask

    task automatic collect(input int delay);
        out_ready = 1'b0;
        for (int i = 0; i < delay; i++) begin
            junk_in(1'b1);
            tick();
        end
        // Beat offered while the result drains must not be taken.
        junk_in(1'b1);
        in_first  = 1'b1;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0; in_valid = 1'b0;
        exp_valid = 1'b0; exp_ready = 1'b1;
    endtask

    task automatic gap(input int n, input logic discard);
        for (int i = 0; i < n; i++) begin
            in_valid = discard; in_first = 1'b0; in_data = 10'($urandom);
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic lit_result(input string name, input logic [9:0] data, input int cnt,
                              input logic nan, input logic ovf);
        chk({name, "_model"}, 32'(m_acc), 32'(data));
        chk({name, "_data"},  32'(out_data), 32'(data));
        chk({name, "_valid"}, 32'(out_valid), 32'(1'b1));
        chk({name, "_cnt"},   32'(op_count), 32'(cnt));
        chk({name, "_nan"},   32'(nan_seen), 32'(nan));
        chk({name, "_ovf"},   32'(ovf_seen), 32'(ovf));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic d;
        int   nops;
        reset = 1'b1; in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
        in_data = 10'd0; in_op = 2'b00; out_ready = 1'b0;
        #12;
        chk("rst_in_ready",  32'(in_ready),  32'(1'b1));
        chk("rst_out_valid", 32'(out_valid), 32'(1'b0));
        chk("rst_op_count",  32'(op_count),  32'(0));
        chk("rst_fpu_sel",   32'(fpu_sel),   32'(4'b0001));
        chk("rst_out_data",  32'(out_data),  32'(0));
        reset = 1'b0;
        model_reset();
        chk_en = 1'b1;
        tick();

        // 1: 1.0 + 1.0, then * 3.0 -> 6.0
        beat_first(10'h0E0, 1'b0);
        beat_op(10'h0E0, 2'b00, 1'b0, d);
        beat_op(10'h110, 2'b10, 1'b1, d);
        lit_result("t1", 10'h130, 2, 1'b0, 1'b0);
        collect(0);
        // 2: 2.0 - 2.0 -> +0
        beat_first(10'h100, 1'b0);
        beat_op(10'h100, 2'b01, 1'b1, d);
        lit_result("t2", 10'h000, 1, 1'b0, 1'b0);
        collect(1);
        // 3: 128 * 2 overflows to +inf
        beat_first(10'h1C0, 1'b0);
        beat_op(10'h100, 2'b10, 1'b1, d);
        lit_result("t3", 10'h1E0, 1, 1'b0, 1'b1);
        collect(0);
        // 4: NaN propagates; NOP leaves acc alone
        beat_first(10'h0E0, 1'b0);
        beat_op(10'h3FF, 2'b00, 1'b0, d);
        beat_op(10'h0E0, 2'b11, 1'b1, d);
        lit_result("t4", 10'h3FF, 2, 1'b1, 1'b0);
        collect(0);
        // 5: chain ends on its own at the op limit
        beat_first(10'h0E0, 1'b0);
        for (int i = 0; i < 15; i++) beat_op(10'h000, 2'b00, 1'b0, d);
        lit_result("t5", 10'h0E0, 15, 1'b0, 1'b0);
        // 7: result held under back-pressure (checked every cycle)
        collect(5);
        // first+last beat: A returned unchanged
        beat_first(10'h2E0, 1'b1);
        lit_result("t_single", 10'h2E0, 0, 1'b0, 1'b0);
        collect(2);

        // 6: reset while executing
        beat_first(10'h0E0, 1'b0);
        beat_op(10'h0E0, 2'b00, 1'b0, d);
        in_valid = 1'b1; in_first = 1'b0; in_last = 1'b1; in_data = 10'h100; in_op = 2'b00;
        tick();
        in_valid = 1'b0;
        chk_en = 1'b0;
        chk("t6_pre_cnt", 32'(op_count), 32'(1));
        #1 reset = 1'b1;
        #1;
        chk("t6_in_ready",  32'(in_ready),  32'(1'b1));
        chk("t6_out_valid", 32'(out_valid), 32'(1'b0));
        chk("t6_op_count",  32'(op_count),  32'(0));
        chk("t6_fpu_a",     32'(fpu_a),     32'(0));
        chk("t6_fpu_b",     32'(fpu_b),     32'(0));
        chk("t6_out_data",  32'(out_data),  32'(0));
        model_reset();
        tick();
        reset = 1'b0;
        chk_en = 1'b1;
        gap(3, 1'b0);

        // Randomized chains
        for (int c = 0; c < 60; c++) begin
            gap($urandom_range(0, 2), 1'($urandom));
            nops = $urandom_range(0, 17);
            beat_first(rand_val(), nops == 0);
            if (nops != 0) begin
                if ($urandom_range(0, 7) == 0) begin
                    gap($urandom_range(0, 1), 1'b0);
                    beat_first(rand_val(), 1'b0);   // restart, no output expected
                end
                for (int i = 0; i < nops; i++) begin
                    gap($urandom_range(0, 2), 1'b0);
                    beat_op(rand_val(), 2'($urandom), i == nops - 1, d);
                    if (d) break;
                end
            end
            collect($urandom_range(0, 3));
        end

        gap(2, 1'b0);
        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
